// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
package alu_arbiter_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_ALUC_W = 4;

  // ALU opcode map
  localparam logic [3:0] ALUC_ADDU  = 4'b0000;
  localparam logic [3:0] ALUC_SUBU  = 4'b0001;
  localparam logic [3:0] ALUC_ADD   = 4'b0010;
  localparam logic [3:0] ALUC_SUB   = 4'b0011;
  localparam logic [3:0] ALUC_AND   = 4'b0100;
  localparam logic [3:0] ALUC_OR    = 4'b0101;
  localparam logic [3:0] ALUC_XOR   = 4'b0110;
  localparam logic [3:0] ALUC_NOR   = 4'b0111;
  localparam logic [3:0] ALUC_LUI   = 4'b1000;
  localparam logic [3:0] ALUC_CLZ   = 4'b1001;
  localparam logic [3:0] ALUC_SLTU  = 4'b1010;
  localparam logic [3:0] ALUC_SLT   = 4'b1011;
  localparam logic [3:0] ALUC_SRA   = 4'b1100;
  localparam logic [3:0] ALUC_SRL   = 4'b1101;
  localparam logic [3:0] ALUC_SLLA  = 4'b1110;
  localparam logic [3:0] ALUC_SLLA2 = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef struct packed {
    logic zero;
    logic neg;
  } flags_t;

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic       sel,
  output logic       any
);

  // Lone requester wins outright; contention resolved by prio.
  always_comb begin
    any = |valid;
    sel = (valid == 2'b11) ? prio : valid[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between execute stage (port 0) and branch/compare unit (port 1).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int ALUC_W  = ALU_ALUC_W,
  parameter int RR_INIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [ALUC_W-1:0] req0_aluc,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [ALUC_W-1:0] req1_aluc,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_r,
  output logic              rsp_zero,
  output logic              rsp_negative,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [ALUC_W-1:0] alu_aluc,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_zero,
  input  logic              alu_negative
);

  state_t              state_q, state_d;
  logic                prio, gnt;
  logic [DATA_W-1:0]   op_a, op_b, res;
  logic [ALUC_W-1:0]   op_aluc;
  flags_t              flag0, flag1, flag_sel;
  logic                sel, any, accept, rsp_hs;

  rr_pick2 u_pick (
    .valid ({req1_valid, req0_valid}),
    .prio  (prio),
    .sel   (sel),
    .any   (any)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    rsp_hs     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          accept     = 1'b1;
          req0_ready = ~sel;
          req1_ready = sel;
          state_d    = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp0_valid = ~gnt;
        rsp1_valid = gnt;
        if (gnt ? rsp1_ready : rsp0_ready) begin
          rsp_hs  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, result/flag capture and priority rotation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio    <= 1'(RR_INIT);
      gnt     <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_aluc <= '0;
      res     <= '0;
      flag0   <= '0;
      flag1   <= '0;
    end else begin
      if (accept) begin
        op_a    <= sel ? req1_a    : req0_a;
        op_b    <= sel ? req1_b    : req0_b;
        op_aluc <= sel ? req1_aluc : req0_aluc;
        gnt     <= sel;
      end
      if (state_q == EXEC) begin
        res <= alu_r;
        if (op_aluc == ALUC_W'(ALUC_SUB)) begin
          if (gnt) flag1 <= '{zero: alu_zero, neg: alu_negative};
          else     flag0 <= '{zero: alu_zero, neg: alu_negative};
        end
      end
      if (rsp_hs) prio <= ~gnt;
    end
  end

  // ALU drive and response data always come from registered state
  always_comb begin
    alu_a        = op_a;
    alu_b        = op_b;
    alu_aluc     = op_aluc;
    flag_sel     = gnt ? flag1 : flag0;
    rsp_r        = res;
    rsp_zero     = flag_sel.zero;
    rsp_negative = flag_sel.neg;
  end

endmodule
